// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for two requesters (ALU, load unit) with a register scoreboard.
// Round-robin grant, 1-cycle registered write port, issue hazard check and sticky error flag.
`ifndef XLEN
`define XLEN 32
`endif

module regfile_wb_arbiter #(
  parameter int unsigned XLEN = `XLEN,
  parameter int unsigned NREG = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_Iss_valid,
  input  logic [4:0]      i_Iss_rd,
  input  logic [4:0]      i_Iss_rs1,
  input  logic [4:0]      i_Iss_rs2,
  output logic            o_Iss_ready,
  input  logic            i_A_valid,
  input  logic [4:0]      i_A_rd,
  input  logic [XLEN-1:0] i_A_data,
  output logic            o_A_ready,
  input  logic            i_B_valid,
  input  logic [4:0]      i_B_rd,
  input  logic [XLEN-1:0] i_B_data,
  output logic            o_B_ready,
  output logic            o_Wen,
  output logic [4:0]      o_Wnum,
  output logic [XLEN-1:0] o_Wd,
  output logic [NREG-1:0] o_Busy,
  output logic            o_Err
);

  logic            prio_b_q, prio_b_d;
  logic            wen_q, wen_d;
  logic [4:0]      wnum_q, wnum_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  logic            grant_a, grant_b, grant;
  logic [4:0]      grant_rd;
  logic [XLEN-1:0] grant_data;
  logic            iss_accept;

  // Index 0 and out-of-range indices always read as not busy.
  function automatic logic busy_of(input logic [NREG-1:0] b, input logic [4:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned n = 1; n < NREG; n++) begin
      if (32'(idx) == n) r = b[n];
    end
    return r;
  endfunction

  always_comb begin
    grant_a = !i_rst && i_A_valid && (!i_B_valid || !prio_b_q);
    grant_b = !i_rst && i_B_valid && (!i_A_valid || prio_b_q);
    grant   = grant_a || grant_b;
    grant_rd   = grant_b ? i_B_rd   : i_A_rd;
    grant_data = grant_b ? i_B_data : i_A_data;

    o_A_ready   = grant_a;
    o_B_ready   = grant_b;
    o_Iss_ready = !i_rst && !busy_of(busy_q, i_Iss_rs1) && !busy_of(busy_q, i_Iss_rs2)
                  && !busy_of(busy_q, i_Iss_rd);
    iss_accept  = i_Iss_valid && o_Iss_ready;
  end

  always_comb begin
    prio_b_d = prio_b_q;
    if (grant_a) prio_b_d = 1'b1;
    if (grant_b) prio_b_d = 1'b0;

    wen_d  = grant && (grant_rd != 5'd0);
    wnum_d = grant ? grant_rd   : wnum_q;
    wd_d   = grant ? grant_data : wd_q;

    err_d = err_q;
    if (grant && (grant_rd != 5'd0) && !busy_of(busy_q, grant_rd)) err_d = 1'b1;

    // Clear from the committing write first, then set from issue so set wins.
    busy_d = busy_q;
    for (int unsigned n = 0; n < NREG; n++) begin
      if (wen_q && (32'(wnum_q) == n)) busy_d[n] = 1'b0;
      if (iss_accept && (32'(i_Iss_rd) == n)) busy_d[n] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prio_b_q <= 1'b0;
      wen_q    <= 1'b0;
      wnum_q   <= '0;
      wd_q     <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      prio_b_q <= prio_b_d;
      wen_q    <= wen_d;
      wnum_q   <= wnum_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign o_Wen  = wen_q;
  assign o_Wnum = wnum_q;
  assign o_Wd   = wd_q;
  assign o_Busy = busy_q;
  assign o_Err  = err_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, write-back, arbitration, hazards, error and async reset.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_Iss_valid;
  logic [4:0]      i_Iss_rd, i_Iss_rs1, i_Iss_rs2;
  logic            o_Iss_ready;
  logic            i_A_valid;
  logic [4:0]      i_A_rd;
  logic [XLEN-1:0] i_A_data;
  logic            o_A_ready;
  logic            i_B_valid;
  logic [4:0]      i_B_rd;
  logic [XLEN-1:0] i_B_data;
  logic            o_B_ready;
  logic            o_Wen;
  logic [4:0]      o_Wnum;
  logic [XLEN-1:0] o_Wd;
  logic [NREG-1:0] o_Busy;
  logic            o_Err;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(.XLEN(XLEN), .NREG(NREG)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_Iss_valid(i_Iss_valid), .i_Iss_rd(i_Iss_rd), .i_Iss_rs1(i_Iss_rs1),
    .i_Iss_rs2(i_Iss_rs2), .o_Iss_ready(o_Iss_ready),
    .i_A_valid(i_A_valid), .i_A_rd(i_A_rd), .i_A_data(i_A_data), .o_A_ready(o_A_ready),
    .i_B_valid(i_B_valid), .i_B_rd(i_B_rd), .i_B_data(i_B_data), .o_B_ready(o_B_ready),
    .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd), .o_Busy(o_Busy), .o_Err(o_Err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rd);
    i_Iss_valid = 1'b1; i_Iss_rd = rd; i_Iss_rs1 = 5'd0; i_Iss_rs2 = 5'd0;
    tick();
    i_Iss_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_Iss_valid = 1'b0; i_Iss_rd = '0; i_Iss_rs1 = '0; i_Iss_rs2 = '0;
    i_A_valid = 1'b1; i_A_rd = 5'd1; i_A_data = '0;
    i_B_valid = 1'b0; i_B_rd = '0; i_B_data = '0;
    tick();
    tick();
    check("rst_wen", o_Wen, 0);
    check("rst_wnum", o_Wnum, 0);
    check("rst_wd", o_Wd, 0);
    check("rst_busy", o_Busy, 0);
    check("rst_err", o_Err, 0);
    check("rst_a_ready", o_A_ready, 0);
    check("rst_iss_ready", o_Iss_ready, 0);
    i_A_valid = 1'b0;
    i_rst = 1'b0;
    tick();

    // Issue x5, then A writes it back.
    i_Iss_valid = 1'b1; i_Iss_rd = 5'd5;
    #1 check("iss5_ready", o_Iss_ready, 1);
    tick();
    i_Iss_valid = 1'b0;
    check("busy_x5", o_Busy, 64'h20);
    i_A_valid = 1'b1; i_A_rd = 5'd5; i_A_data = 32'hDEADBEEF;
    #1 check("a5_ready", o_A_ready, 1);
    check("a5_b_ready", o_B_ready, 0);
    tick();
    i_A_valid = 1'b0;
    check("w5_wen", o_Wen, 1);
    check("w5_wnum", o_Wnum, 5);
    check("w5_wd", o_Wd, 64'hDEADBEEF);
    check("w5_busy_held", o_Busy, 64'h20);
    tick();
    check("w5_busy_clr", o_Busy, 0);
    check("w5_wen_off", o_Wen, 0);
    check("w5_wnum_hold", o_Wnum, 5);
    check("w5_err", o_Err, 0);

    // Reserve x3, x4; B writes x0 (consumed, no write).
    issue(5'd3);
    issue(5'd4);
    check("busy_x3x4", o_Busy, 64'h18);
    i_B_valid = 1'b1; i_B_rd = 5'd0; i_B_data = 32'h1;
    #1 check("b0_ready", o_B_ready, 1);
    check("b0_a_ready", o_A_ready, 0);
    tick();
    i_B_valid = 1'b0;
    check("b0_wen", o_Wen, 0);
    check("b0_busy", o_Busy, 64'h18);

    // Contention: last grant was B, so A wins, then B.
    i_A_valid = 1'b1; i_A_rd = 5'd3; i_A_data = 32'h33;
    i_B_valid = 1'b1; i_B_rd = 5'd4; i_B_data = 32'h44;
    #1 check("rr1_a_ready", o_A_ready, 1);
    check("rr1_b_ready", o_B_ready, 0);
    tick();
    i_A_valid = 1'b0;
    check("rr1_wnum", o_Wnum, 3);
    check("rr1_wd", o_Wd, 64'h33);
    #1 check("rr2_b_ready", o_B_ready, 1);
    tick();
    i_B_valid = 1'b0;
    check("rr2_wen", o_Wen, 1);
    check("rr2_wnum", o_Wnum, 4);
    check("rr2_wd", o_Wd, 64'h44);
    check("rr2_busy", o_Busy, 64'h10);
    tick();
    check("rr_busy_clr", o_Busy, 0);
    check("rr_err", o_Err, 0);

    // Hazard on rs1=x7 until its write commits.
    issue(5'd7);
    i_Iss_valid = 1'b1; i_Iss_rd = 5'd1; i_Iss_rs1 = 5'd7; i_Iss_rs2 = 5'd0;
    #1 check("haz_ready0", o_Iss_ready, 0);
    i_A_valid = 1'b1; i_A_rd = 5'd7; i_A_data = 32'h77;
    tick();
    i_A_valid = 1'b0;
    check("haz_wen", o_Wen, 1);
    check("haz_ready_commit", o_Iss_ready, 0);
    tick();
    check("haz_ready1", o_Iss_ready, 1);
    i_Iss_valid = 1'b0; i_Iss_rs1 = 5'd0;

    // Write to a non-reserved register flags an error, still written.
    i_A_valid = 1'b1; i_A_rd = 5'd9; i_A_data = 32'h99;
    tick();
    i_A_valid = 1'b0;
    check("err_set", o_Err, 1);
    check("err_wen", o_Wen, 1);
    check("err_wnum", o_Wnum, 9);
    tick();
    check("err_sticky", o_Err, 1);

    // Async reset while a write is in flight and x12 reserved.
    i_Iss_valid = 1'b1; i_Iss_rd = 5'd12;
    i_A_valid = 1'b1; i_A_rd = 5'd10; i_A_data = 32'hAA;
    tick();
    i_Iss_valid = 1'b0; i_A_valid = 1'b0;
    check("pre_rst_wen", o_Wen, 1);
    check("pre_rst_busy", o_Busy, 64'h1000);
    #2 i_rst = 1'b1;
    #1 check("arst_wen", o_Wen, 0);
    check("arst_busy", o_Busy, 0);
    check("arst_err", o_Err, 0);
    check("arst_wnum", o_Wnum, 0);
    check("arst_iss_ready", o_Iss_ready, 0);
    tick();
    i_rst = 1'b0;

    // First contention after reset goes to A.
    i_A_valid = 1'b1; i_A_rd = 5'd2; i_A_data = 32'h12;
    i_B_valid = 1'b1; i_B_rd = 5'd6; i_B_data = 32'h16;
    #1 check("post_rst_a_ready", o_A_ready, 1);
    check("post_rst_b_ready", o_B_ready, 0);
    tick();
    i_A_valid = 1'b0; i_B_valid = 1'b0;
    check("post_rst_wnum", o_Wnum, 2);
    check("post_rst_wd", o_Wd, 64'h12);
    check("post_rst_err", o_Err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
